// File: rtl/activation_stream_fifo_if.sv
// Handshake bundle between the line-buffer stream reader, this FIFO and the compute array.
// Reader side: i_stream_valid / o_stream_ready / i_stream_data; consumer side: o_data / o_valid / i_ready.
// The master modport is the environment driving the FIFO; the slave modport is the FIFO itself.
interface activation_stream_fifo_if #(
   parameter int DATA_WIDTH = 64,
   parameter int FIFO_DEPTH = 8
);
   logic                                i_stream_valid;
   logic                                o_stream_ready;
   logic [DATA_WIDTH-1:0]               i_stream_data;
   logic [DATA_WIDTH-1:0]               o_data;
   logic                                o_valid;
   logic                                i_ready;
   logic [$clog2(FIFO_DEPTH+1)-1:0]     o_count;

   modport master (
      output i_stream_valid, i_stream_data, i_ready,
      input  o_stream_ready, o_data, o_valid, o_count
   );

   modport slave (
      input  i_stream_valid, i_stream_data, i_ready,
      output o_stream_ready, o_data, o_valid, o_count
   );
endinterface

// File: rtl/activation_stream_fifo.sv
// Captures line-buffer read data returning READ_LATENCY cycles after each read into an FWFT FIFO.
// Latency: read handshake to o_valid is READ_LATENCY+1 cycles when empty; 1 word/cycle sustained.
// Backpressure: reader ready is credit based (stored + in-flight < depth), so returning data never drops.
module activation_stream_fifo #(
   parameter int DATA_WIDTH   = 64,
   parameter int FIFO_DEPTH   = 8,
   parameter int READ_LATENCY = 2
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    i_local_resetn,
   activation_stream_fifo_if.slave bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int IF_W  = $clog2(READ_LATENCY + 1);
   localparam int SUM_W = $clog2(FIFO_DEPTH + READ_LATENCY + 1);

   logic [READ_LATENCY-1:0] pipe;
   logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
   logic [PTR_W-1:0]        wr_ptr;
   logic [PTR_W-1:0]        rd_ptr;
   logic [CNT_W-1:0]        count;
   logic [IF_W-1:0]         inflight;
   logic [SUM_W-1:0]        credit_used;
   logic                    ready;
   logic                    valid;
   logic                    accept;
   logic                    push;
   logic                    pop;

   // Number of reads still travelling through the line-buffer RAM latency.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
         inflight = inflight + IF_W'(pipe[i]);
      end
   end

   // Every accepted read owns a FIFO slot from handshake until it is popped, so a
   // pop only frees its credit once count has actually dropped (one cycle later).
   assign credit_used = SUM_W'(count) + SUM_W'(inflight);
   assign ready       = resetn && i_local_resetn && (credit_used < SUM_W'(FIFO_DEPTH));
   assign valid       = i_local_resetn && (count != '0);
   assign accept      = bus.i_stream_valid && ready;
   assign push        = pipe[READ_LATENCY-1];
   assign pop         = valid && bus.i_ready;

   assign bus.o_stream_ready = ready;
   assign bus.o_valid        = valid;
   assign bus.o_data         = mem[rd_ptr];
   assign bus.o_count        = count;

   // Valid-only delay pipe mirroring the RAM read latency; data itself is not delayed.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pipe <= '0;
      end else if (!i_local_resetn) begin
         pipe <= '0;
      end else begin
         pipe[0] <= accept;
         for (int i = 1; i < READ_LATENCY; i++) begin
            pipe[i] <= pipe[i-1];
         end
      end
   end

   // Pointer and occupancy bookkeeping; a flush drops stored and in-flight words alike.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (!i_local_resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array; cleared on hard reset so o_data reads zero out of reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push && i_local_resetn) begin
         mem[wr_ptr] <= bus.i_stream_data;
      end
   end

   // The credit scheme must make a write into a full FIFO without a pop unreachable.
   assert property (@(posedge clk) disable iff (!resetn || !i_local_resetn)
                    !(push && (count == CNT_W'(FIFO_DEPTH)) && !pop));

endmodule

// File: tb/tb_activation_stream_fifo.sv
// Directed bench for activation_stream_fifo with DEPTH=8, READ_LATENCY=2.
// A two-stage line-buffer model returns the beat index of each accepted read two edges later.
// Each scenario task compares DUT outputs against hand-derived expectations.
module tb_activation_stream_fifo;
   logic clk;
   logic resetn;
   logic i_local_resetn;

   activation_stream_fifo_if #(.DATA_WIDTH(64), .FIFO_DEPTH(8)) bus ();

   activation_stream_fifo #(
      .DATA_WIDTH  (64),
      .FIFO_DEPTH  (8),
      .READ_LATENCY(2)
   ) dut (
      .clk           (clk),
      .resetn        (resetn),
      .i_local_resetn(i_local_resetn),
      .bus           (bus)
   );

   int          tests = 0;
   int          fails = 0;
   logic        lb_v [2];
   logic [63:0] lb_d [2];
   logic [63:0] issue_idx;
   logic        accepted;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock: sample the handshake mid-cycle, then advance the line-buffer model after the edge.
   task automatic cycle();
      @(negedge clk);
      accepted = bus.i_stream_valid && bus.o_stream_ready;
      @(posedge clk);
      #1;
      lb_v[1] = lb_v[0];
      lb_d[1] = lb_d[0];
      lb_v[0] = accepted;
      lb_d[0] = issue_idx;
      if (accepted) issue_idx = issue_idx + 64'd1;
      bus.i_stream_data = lb_v[1] ? lb_d[1] : 64'hBAD0_BAD0_BAD0_BAD0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      for (int c = 0; c < 4; c++) begin
         bus.i_stream_valid = 1'($urandom_range(0, 1));
         bus.i_ready        = 1'($urandom_range(0, 1));
         i_local_resetn     = 1'($urandom_range(0, 1));
         bus.i_stream_data  = {$urandom, $urandom};
         @(posedge clk);
         #1;
      end
      tests++; if (bus.o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", bus.o_valid); end
      tests++; if (bus.o_stream_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", bus.o_stream_ready); end
      tests++; if (bus.o_count !== 4'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", bus.o_count); end
      tests++; if (bus.o_data !== 64'd0) begin fails++; $display("FAIL reset_data: got %h want 0", bus.o_data); end
      bus.i_stream_valid = 1'b0;
      bus.i_ready        = 1'b0;
      bus.i_stream_data  = 64'd0;
      i_local_resetn     = 1'b1;
      resetn             = 1'b1;
      cycle();
      tests++; if (bus.o_stream_ready !== 1'b1) begin fails++; $display("FAIL release_ready: got %b want 1", bus.o_stream_ready); end
   endtask

   task automatic test_single_beat();
      issue_idx = 64'hA5;
      bus.i_stream_valid = 1'b1;
      cycle();                       // handshake at cycle 0
      bus.i_stream_valid = 1'b0;
      cycle();                       // now cycle 2, data on the bus
      tests++; if (bus.o_valid !== 1'b0) begin fails++; $display("FAIL single_early_valid: got %b want 0", bus.o_valid); end
      cycle();                       // cycle 3
      tests++; if (bus.o_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b want 1", bus.o_valid); end
      tests++; if (bus.o_data !== 64'hA5) begin fails++; $display("FAIL single_data: got %h want a5", bus.o_data); end
      tests++; if (bus.o_count !== 4'd1) begin fails++; $display("FAIL single_count: got %0d want 1", bus.o_count); end
      bus.i_ready = 1'b1;
      cycle();                       // cycle 4
      tests++; if (bus.o_valid !== 1'b0) begin fails++; $display("FAIL single_pop_valid: got %b want 0", bus.o_valid); end
      tests++; if (bus.o_count !== 4'd0) begin fails++; $display("FAIL single_pop_count: got %0d want 0", bus.o_count); end
      bus.i_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      int hs = 0;
      int ready_bad = 0;
      logic [63:0] exp = 64'd0;
      issue_idx = 64'd0;
      bus.i_ready = 1'b0;
      bus.i_stream_valid = 1'b1;
      for (int c = 0; c < 14; c++) begin
         if (bus.i_stream_valid && bus.o_stream_ready) hs++;
         cycle();
         if (hs >= 8 && bus.o_stream_ready) ready_bad++;
      end
      tests++; if (hs !== 8) begin fails++; $display("FAIL bp_handshakes: got %0d want 8", hs); end
      tests++; if (ready_bad !== 0) begin fails++; $display("FAIL bp_ready_after_full: got %0d high cycles want 0", ready_bad); end
      tests++; if (bus.o_count !== 4'd8) begin fails++; $display("FAIL bp_count_full: got %0d want 8", bus.o_count); end
      bus.i_stream_valid = 1'b0;
      bus.i_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (bus.o_valid && bus.i_ready) begin
            tests++; if (bus.o_data !== exp) begin fails++; $display("FAIL bp_drain_data: got %h want %h", bus.o_data, exp); end
            exp = exp + 64'd1;
         end
         cycle();
      end
      tests++; if (exp !== 64'd8) begin fails++; $display("FAIL bp_drain_total: got %0d want 8", exp); end
      tests++; if (bus.o_count !== 4'd0) begin fails++; $display("FAIL bp_drain_count: got %0d want 0", bus.o_count); end
   endtask

   task automatic test_streaming();
      logic [63:0] exp = 64'd0;
      int first_pop = -1;
      int last_pop = -1;
      int ready_drop = 0;
      int max_cnt = 0;
      issue_idx = 64'd0;
      bus.i_ready = 1'b1;
      for (int c = 0; c < 60; c++) begin
         bus.i_stream_valid = (issue_idx < 64'd32);
         if (bus.i_stream_valid && !bus.o_stream_ready) ready_drop++;
         if (bus.o_valid && bus.i_ready) begin
            tests++; if (bus.o_data !== exp) begin fails++; $display("FAIL stream_data: got %h want %h", bus.o_data, exp); end
            exp = exp + 64'd1;
            if (first_pop < 0) first_pop = c;
            last_pop = c;
         end
         cycle();
         if (int'(bus.o_count) > max_cnt) max_cnt = int'(bus.o_count);
      end
      bus.i_stream_valid = 1'b0;
      tests++; if (exp !== 64'd32) begin fails++; $display("FAIL stream_total: got %0d want 32", exp); end
      tests++; if (first_pop !== 3) begin fails++; $display("FAIL stream_first_pop: got cycle %0d want 3", first_pop); end
      tests++; if (last_pop !== 34) begin fails++; $display("FAIL stream_last_pop: got cycle %0d want 34", last_pop); end
      tests++; if (ready_drop !== 0) begin fails++; $display("FAIL stream_ready_drop: got %0d want 0", ready_drop); end
      tests++; if (max_cnt > 1) begin fails++; $display("FAIL stream_max_count: got %0d want <=1", max_cnt); end
   endtask

   task automatic test_wrap_random();
      logic [63:0] exp = 64'd0;
      void'($urandom(32'h00C0FFEE));
      issue_idx = 64'd0;
      for (int c = 0; c < 600; c++) begin
         if (exp == 64'd40) break;
         bus.i_stream_valid = (issue_idx < 64'd40) && 1'($urandom_range(0, 1));
         bus.i_ready        = 1'($urandom_range(0, 1));
         if (bus.o_valid && bus.i_ready) begin
            tests++; if (bus.o_data !== exp) begin fails++; $display("FAIL wrap_data: got %h want %h", bus.o_data, exp); end
            exp = exp + 64'd1;
         end
         cycle();
      end
      bus.i_stream_valid = 1'b0;
      bus.i_ready = 1'b0;
      tests++; if (exp !== 64'd40) begin fails++; $display("FAIL wrap_total: got %0d want 40", exp); end
      tests++; if (bus.o_count !== 4'd0) begin fails++; $display("FAIL wrap_final_count: got %0d want 0", bus.o_count); end
   endtask

   task automatic test_flush();
      int pops = 0;
      issue_idx = 64'd100;
      bus.i_ready = 1'b0;
      bus.i_stream_valid = 1'b1;
      for (int c = 0; c < 5; c++) cycle();
      tests++; if (bus.o_count !== 4'd3) begin fails++; $display("FAIL flush_pre_count: got %0d want 3", bus.o_count); end
      bus.i_stream_valid = 1'b0;
      i_local_resetn = 1'b0;
      #1;
      tests++; if (bus.o_stream_ready !== 1'b0) begin fails++; $display("FAIL flush_ready_low: got %b want 0", bus.o_stream_ready); end
      tests++; if (bus.o_valid !== 1'b0) begin fails++; $display("FAIL flush_valid_low: got %b want 0", bus.o_valid); end
      cycle();
      i_local_resetn = 1'b1;
      #1;
      tests++; if (bus.o_count !== 4'd0) begin fails++; $display("FAIL flush_count: got %0d want 0", bus.o_count); end
      tests++; if (bus.o_valid !== 1'b0) begin fails++; $display("FAIL flush_valid: got %b want 0", bus.o_valid); end
      for (int c = 0; c < 3; c++) cycle();
      tests++; if (bus.o_count !== 4'd0) begin fails++; $display("FAIL flush_inflight_ignored: got %0d want 0", bus.o_count); end
      issue_idx = 64'h5A;
      bus.i_stream_valid = 1'b1;
      cycle();
      bus.i_stream_valid = 1'b0;
      bus.i_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         if (bus.o_valid && bus.i_ready) begin
            tests++; if (bus.o_data !== 64'h5A) begin fails++; $display("FAIL flush_new_data: got %h want 5a", bus.o_data); end
            pops++;
         end
         cycle();
      end
      tests++; if (pops !== 1) begin fails++; $display("FAIL flush_new_pops: got %0d want 1", pops); end
      bus.i_ready = 1'b0;
   endtask

   task automatic test_async_reset();
      issue_idx = 64'd200;
      bus.i_ready = 1'b0;
      bus.i_stream_valid = 1'b1;
      for (int c = 0; c < 4; c++) cycle();
      bus.i_stream_valid = 1'b0;
      tests++; if (bus.o_count !== 4'd2) begin fails++; $display("FAIL areset_pre_count: got %0d want 2", bus.o_count); end
      #2;
      resetn = 1'b0;
      #1;
      tests++; if (bus.o_count !== 4'd0) begin fails++; $display("FAIL areset_count: got %0d want 0", bus.o_count); end
      tests++; if (bus.o_valid !== 1'b0) begin fails++; $display("FAIL areset_valid: got %b want 0", bus.o_valid); end
      tests++; if (bus.o_stream_ready !== 1'b0) begin fails++; $display("FAIL areset_ready: got %b want 0", bus.o_stream_ready); end
      resetn = 1'b1;
      cycle();
      cycle();
      tests++; if (bus.o_count !== 4'd0) begin fails++; $display("FAIL areset_inflight_ignored: got %0d want 0", bus.o_count); end
      tests++; if (bus.o_stream_ready !== 1'b1) begin fails++; $display("FAIL areset_ready_back: got %b want 1", bus.o_stream_ready); end
   endtask

   initial begin
      lb_v[0] = 1'b0;
      lb_v[1] = 1'b0;
      lb_d[0] = 64'd0;
      lb_d[1] = 64'd0;
      issue_idx = 64'd0;
      accepted = 1'b0;
      resetn = 1'b0;
      i_local_resetn = 1'b1;
      bus.i_stream_valid = 1'b0;
      bus.i_ready = 1'b0;
      bus.i_stream_data = 64'd0;
      test_reset();
      test_single_beat();
      test_backpressure();
      test_streaming();
      test_wrap_random();
      test_flush();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/activation_stream_fifo.md
Name: activation_stream_fifo

Overview:
- Consumer stage directly downstream of the activation line-buffer stream reader.
- The reader issues read addresses. This block:
  - tracks reads that are in flight through the line-buffer RAM latency,
  - captures the returning data into a small first-word-fall-through (FWFT) FIFO,
  - presents it to the compute array with valid/ready.
- It generates the reader's ready from credit accounting, so no returning word is ever dropped.

Parameters:
- DATA_WIDTH, 64, width of one line-buffer read word.
- FIFO_DEPTH, 8, FIFO entries; power of two, at least 4.
- READ_LATENCY, 2, cycles from an accepted read handshake to its data being valid on i_stream_data; at least 1.

Ports:
- clk  input  1  clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- i_local_resetn  input  1  synchronous active-low flush (latched register-file local reset).
- i_stream_valid  input  1  read-issued valid from the stream reader.
- o_stream_ready  output  1  ready back to the stream reader.
- i_stream_data  input  DATA_WIDTH  line-buffer read data, READ_LATENCY cycles after the handshake.
- o_data  output  DATA_WIDTH  FIFO head word.
- o_valid  output  1  head word valid.
- i_ready  input  1  downstream ready.
- o_count  output  $clog2(FIFO_DEPTH+1)  stored entries, excluding in-flight reads.

Behaviour:
- Reset (resetn low, asynchronous): clears pointers, count and the delay pipe. o_valid=0, o_stream_ready=0, o_count=0, o_data=0.
- Accept event: i_stream_valid && o_stream_ready at a rising edge.
- Delay pipe:
  - READ_LATENCY-deep shift register of valid bits; bit 0 is loaded with the accept event.
  - inflight = popcount of the pipe.
  - When the final stage is 1, i_stream_data is sampled that cycle and written at the FIFO write pointer.
  - The data path is not delayed; only valid is.
- Credit rule:
  - o_stream_ready = resetn && i_local_resetn && (count + inflight < FIFO_DEPTH).
  - Driven from registers only; no combinational path from i_stream_valid or i_ready.
  - A pop in the same cycle does not raise ready until the next cycle (conservative by design).
- Pop event: o_valid && i_ready.
  - Head advances; o_data shows the next entry the following cycle.
  - o_valid = (count != 0). o_data = mem[rd_ptr], read combinationally from the registered array.
- Push and pop in the same cycle: count unchanged, both pointers advance. Full throughput of 1 word/cycle is sustained.
- Latency: data captured at edge E (delayed valid high at E) gives o_valid=1 in the cycle after E.
  - Handshake to o_valid is READ_LATENCY+1 cycles when the FIFO is empty.
- Pointers: log2(FIFO_DEPTH) bits with natural wrap. count is a separate counter.
- Overflow is impossible by construction. An assertion checks that no write occurs with count==FIFO_DEPTH without a simultaneous pop.
- Pop on empty is impossible because o_valid=0.
- Flush (i_local_resetn low at an edge): the same edge clears count, pointers and the delay pipe.
  - In-flight data is discarded, even if it arrives while the flush is held.
  - o_stream_ready=0 and o_valid=0 while the flush is low.
  - Normal operation resumes on the first edge after i_local_resetn returns high.
- resetn asserted mid-operation: immediate clear, identical end state to a flush.
- o_count updates on the edge of each push/pop and reflects stored entries only.

Test Plan:
All scenarios use FIFO_DEPTH=8 and READ_LATENCY=2.
1. Reset with resetn=0 and random inputs → o_valid=0, o_stream_ready=0, o_count=0. Cycle 1 after release with i_local_resetn=1 → o_stream_ready=1.
2. Single beat: handshake at cycle 0, i_stream_data=0xA5 at cycle 2 → o_valid=1 and o_data=0xA5 at cycle 3. With i_ready=1 → o_valid=0 at cycle 4, o_count back to 0.
3. Backpressure: i_ready=0, i_stream_valid held 1, data = beat index → exactly 8 handshakes. o_stream_ready falls after the 8th and stays 0. o_count reaches 8. Then i_ready=1 drains 0..7 in order, with no duplicates or losses.
4. Streaming: i_ready=1, 32 consecutive beats, data 0..31 → outputs 0..31 on consecutive cycles after a 3-cycle fill. o_stream_ready never drops; o_count ≤ 1.
5. Wrap and random stall: 40 beats with random i_stream_valid and i_ready (seeded, 50%) → output order equals input order. Pointers wrap 5 times; a scoreboard sees no mismatch.
6. Flush mid-operation: 3 entries stored and 2 in flight, pulse i_local_resetn low for 1 cycle → next cycle o_count=0 and o_valid=0. Returning in-flight data is ignored. A new beat 0x5A after the flush comes out as the only word.
